fmap_reader: RTL and testbench

- Read-side counterpart of the PE writeback path. Fetches packed 64-bit feature-map words from the two BRAM32k ports in lockstep.
- Unpacks each word into 8 bytes, least-significant byte first, and streams one byte per channel per cycle to the PE groups over a valid/ready handshake.
- Prefetches up to two words so that a stream with ready held high has no bubbles.

---
 rtl/fmap_reader.sv | 152 +++++++++++++++
 tb/tb_fmap_reader.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fmap_reader.sv
// Streams paired 64-bit feature-map words from two BRAM32k ports as byte pairs (LSB first) over valid/ready.
// Keeps up to two words held or in flight so a continuously ready consumer sees no bubbles.
module fmap_reader #(
  parameter int ADDR_W = 12,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr_1,
  input  logic [ADDR_W-1:0] base_addr_2,
  input  logic [ADDR_W-1:0] word_cnt,
  output logic              en_BRAM32k,
  output logic [ADDR_W-1:0] addr_BRAM32k_1,
  output logic [ADDR_W-1:0] addr_BRAM32k_2,
  input  logic [63:0]       dout_BRAM32k_1,
  input  logic [63:0]       dout_BRAM32k_2,
  output logic              byte_valid,
  input  logic              byte_ready,
  output logic [7:0]        byte_1,
  output logic [7:0]        byte_2,
  output logic              last,
  output logic              busy,
  output logic              done
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0] addr_1, addr_2;
  logic [ADDR_W-1:0] cnt, issued, popped;
  logic [RD_LAT-1:0] pipe;
  logic [1:0]        held, inflight;
  logic [63:0]       buf_1 [2];
  logic [63:0]       buf_2 [2];
  logic              wr_ptr, rd_ptr;
  logic [2:0]        idx;
  logic              done_q;

  logic issue, capture, hs, pop, final_word, finish, load, done_nxt;

  // A read lands in the buffer exactly RD_LAT cycles after its enable.
  assign capture    = pipe[RD_LAT-1];
  assign hs         = byte_valid && byte_ready;
  assign pop        = hs && (idx == 3'd7);
  assign final_word = (popped == cnt - ADDR_W'(1));
  assign finish     = pop && final_word;
  assign issue      = (state == RUN) && (issued < cnt) &&
                      (({1'b0, held} + {1'b0, inflight}) < 3'd2);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (word_cnt != '0) begin
            load      = 1'b1;
            state_nxt = RUN;
          end else begin
            done_nxt = 1'b1;
          end
        end
      end
      RUN: begin
        if (finish) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_1   <= '0;
      addr_2   <= '0;
      cnt      <= '0;
      issued   <= '0;
      popped   <= '0;
      idx      <= '0;
      pipe     <= '0;
      held     <= '0;
      inflight <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        buf_1[i] <= '0;
        buf_2[i] <= '0;
      end
    end else begin
      if (load) begin
        addr_1 <= base_addr_1;
        addr_2 <= base_addr_2;
        cnt    <= word_cnt;
        issued <= '0;
        popped <= '0;
        idx    <= '0;
      end else begin
        if (issue) begin
          addr_1 <= addr_1 + ADDR_W'(1);
          addr_2 <= addr_2 + ADDR_W'(1);
          issued <= issued + ADDR_W'(1);
        end
        if (hs) idx <= idx + 3'd1;
        if (pop) popped <= popped + ADDR_W'(1);
      end

      pipe     <= RD_LAT'({pipe, issue});
      inflight <= inflight + 2'(issue) - 2'(capture);
      held     <= held + 2'(capture) - 2'(pop);

      if (capture) begin
        buf_1[wr_ptr] <= dout_BRAM32k_1;
        buf_2[wr_ptr] <= dout_BRAM32k_2;
        wr_ptr        <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
    end
  end

  assign en_BRAM32k     = issue;
  assign addr_BRAM32k_1 = addr_1;
  assign addr_BRAM32k_2 = addr_2;
  assign byte_valid     = (held != 2'd0);
  assign byte_1         = byte_valid ? buf_1[rd_ptr][{idx, 3'b000} +: 8] : 8'd0;
  assign byte_2         = byte_valid ? buf_2[rd_ptr][{idx, 3'b000} +: 8] : 8'd0;
  assign last           = byte_valid && final_word && (idx == 3'd7);
  assign busy           = (state == RUN);
  assign done           = done_q;

  // held + inflight never exceeds two, so a landing word always finds a free slot.
  assert property (@(posedge clk) disable iff (!rst) capture |-> (held != 2'd2));
  assert property (@(posedge clk) disable iff (!rst) (held + inflight) <= 2'd2);

endmodule

// File: tb/tb_fmap_reader.sv
// Randomized bench for fmap_reader: two instances (RD_LAT 1 and 2) fed from a shared memory image,
// each transfer checked against a byte/address stream computed from the memory contents.
module tb_fmap_reader;
  localparam int AW = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          start_a, start_b, ready, sel;
  logic [AW-1:0] base_1, base_2, wcnt;
  logic [63:0]   mem1 [4096];
  logic [63:0]   mem2 [4096];

  logic          en_a, v_a, l_a, busy_a, done_a;
  logic [AW-1:0] a1_a, a2_a;
  logic [7:0]    b1_a, b2_a;
  logic [63:0]   d1_a = '0, d2_a = '0;

  logic          en_b, v_b, l_b, busy_b, done_b;
  logic [AW-1:0] a1_b, a2_b;
  logic [7:0]    b1_b, b2_b;
  logic [63:0]   s1_b = '0, s2_b = '0, d1_b = '0, d2_b = '0;

  fmap_reader #(.ADDR_W(AW), .RD_LAT(1)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .base_addr_1(base_1), .base_addr_2(base_2),
    .word_cnt(wcnt), .en_BRAM32k(en_a), .addr_BRAM32k_1(a1_a), .addr_BRAM32k_2(a2_a),
    .dout_BRAM32k_1(d1_a), .dout_BRAM32k_2(d2_a), .byte_valid(v_a), .byte_ready(ready),
    .byte_1(b1_a), .byte_2(b2_a), .last(l_a), .busy(busy_a), .done(done_a));

  fmap_reader #(.ADDR_W(AW), .RD_LAT(2)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .base_addr_1(base_1), .base_addr_2(base_2),
    .word_cnt(wcnt), .en_BRAM32k(en_b), .addr_BRAM32k_1(a1_b), .addr_BRAM32k_2(a2_b),
    .dout_BRAM32k_1(d1_b), .dout_BRAM32k_2(d2_b), .byte_valid(v_b), .byte_ready(ready),
    .byte_1(b1_b), .byte_2(b2_b), .last(l_b), .busy(busy_b), .done(done_b));

  always @(posedge clk) begin
    if (en_a) begin
      d1_a <= mem1[a1_a];
      d2_a <= mem2[a2_a];
    end
    if (en_b) begin
      s1_b <= mem1[a1_b];
      s2_b <= mem2[a2_b];
    end
    d1_b <= s1_b;
    d2_b <= s2_b;
  end

  logic          obs_en, obs_v, obs_l, obs_busy, obs_done;
  logic [AW-1:0] obs_a1, obs_a2;
  logic [7:0]    obs_b1, obs_b2;
  assign obs_en   = sel ? en_b   : en_a;
  assign obs_v    = sel ? v_b    : v_a;
  assign obs_l    = sel ? l_b    : l_a;
  assign obs_busy = sel ? busy_b : busy_a;
  assign obs_done = sel ? done_b : done_a;
  assign obs_a1   = sel ? a1_b   : a1_a;
  assign obs_a2   = sel ? a2_b   : a2_a;
  assign obs_b1   = sel ? b1_b   : b1_a;
  assign obs_b2   = sel ? b2_b   : b2_a;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0]    got1[$], got2[$], exp1[$], exp2[$];
  logic [AW-1:0] ga1[$], ga2[$], ea1[$], ea2[$];
  int n_en, n_valid, n_hs, first_valid, bubbles, last_err, stab_err, outst_err;
  int done_cyc, done_busy_err, timeout;

  task automatic build_expected(input logic [AW-1:0] b1, input logic [AW-1:0] b2, input int cnt);
    logic [AW-1:0] x1, x2;
    logic [63:0]   w1, w2;
    exp1.delete(); exp2.delete(); ea1.delete(); ea2.delete();
    for (int w = 0; w < cnt; w++) begin
      x1 = AW'((int'(b1) + w) % 4096);
      x2 = AW'((int'(b2) + w) % 4096);
      ea1.push_back(x1);
      ea2.push_back(x2);
      w1 = mem1[x1];
      w2 = mem2[x2];
      for (int k = 0; k < 8; k++) begin
        exp1.push_back(w1[8*k +: 8]);
        exp2.push_back(w2[8*k +: 8]);
      end
    end
  endtask

  function automatic int stream_diff();
    int d = 0;
    if (got1.size() != exp1.size() || got2.size() != exp2.size()) d++;
    for (int i = 0; i < exp1.size() && i < got1.size(); i++) if (got1[i] !== exp1[i]) d++;
    for (int i = 0; i < exp2.size() && i < got2.size(); i++) if (got2[i] !== exp2[i]) d++;
    return d;
  endfunction

  function automatic int addr_diff();
    int d = 0;
    if (ga1.size() != ea1.size() || ga2.size() != ea2.size()) d++;
    for (int i = 0; i < ea1.size() && i < ga1.size(); i++) if (ga1[i] !== ea1[i]) d++;
    for (int i = 0; i < ea2.size() && i < ga2.size(); i++) if (ga2[i] !== ea2[i]) d++;
    return d;
  endfunction

  // One transfer: cycle n counts from the first cycle after the edge that samples start.
  task automatic run(input logic s, input logic [AW-1:0] b1, input logic [AW-1:0] b2,
                     input int cnt, input int duty, input int mid_at, input int rst_at);
    logic       pv, pr, pl;
    logic [7:0] p1, p2;
    int         n, last_hs_n;
    bit         fin;
    got1.delete(); got2.delete(); ga1.delete(); ga2.delete();
    n_en = 0; n_valid = 0; n_hs = 0; first_valid = -1; bubbles = 0; last_err = 0;
    stab_err = 0; outst_err = 0; done_cyc = -1; done_busy_err = 0; timeout = 0;
    build_expected(b1, b2, cnt);
    sel = s;
    @(posedge clk); #1;
    base_1 = b1; base_2 = b2; wcnt = AW'(cnt);
    if (s) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0; start_b = 1'b0;
    n = 1; fin = 0; last_hs_n = 0; pv = 0; pr = 0; pl = 0; p1 = 0; p2 = 0;
    while (!fin) begin
      ready = ($urandom_range(99) < duty);
      if (n == mid_at) begin
        base_1 = ~b1; base_2 = ~b2; wcnt = AW'(7);
        if (s) start_b = 1'b1; else start_a = 1'b1;
      end else begin
        start_a = 1'b0; start_b = 1'b0;
      end
      @(negedge clk);
      if (obs_en) begin
        n_en++;
        ga1.push_back(obs_a1);
        ga2.push_back(obs_a2);
      end
      if (n_en - (n_hs / 8) > 2) outst_err++;
      if (pv && !pr && (!obs_v || obs_b1 !== p1 || obs_b2 !== p2 || obs_l !== pl)) stab_err++;
      if (obs_v) begin
        n_valid++;
        if (first_valid < 0) first_valid = n;
        if (obs_l !== (n_hs == 8*cnt - 1)) last_err++;
      end else begin
        if (obs_l !== 1'b0) last_err++;
        if (first_valid >= 0 && n_hs < 8*cnt) bubbles++;
      end
      if (obs_v && ready) begin
        got1.push_back(obs_b1);
        got2.push_back(obs_b2);
        n_hs++;
        last_hs_n = n;
      end
      if (obs_done) begin
        done_cyc = n - last_hs_n;
        if (obs_busy !== 1'b0) done_busy_err++;
        fin = 1;
      end
      pv = obs_v; pr = ready; p1 = obs_b1; p2 = obs_b2; pl = obs_l;
      if (rst_at > 0 && n_hs == rst_at) fin = 1;
      if (n >= 3000) begin timeout = 1; fin = 1; end
      @(posedge clk); #1;
      n++;
    end
    ready = 1'b0; start_a = 1'b0; start_b = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({en_a, v_a, l_a, busy_a, done_a, a1_a, a2_a, b1_a, b2_a} !== '0) begin
      miscompares++;
      $display("FAIL reset_a: got %h want 0", {en_a, v_a, l_a, busy_a, done_a, a1_a, a2_a, b1_a, b2_a});
    end
    vectors++;
    if ({en_b, v_b, l_b, busy_b, done_b, a1_b, a2_b, b1_b, b2_b} !== '0) begin
      miscompares++;
      $display("FAIL reset_b: got %h want 0", {en_b, v_b, l_b, busy_b, done_b, a1_b, a2_b, b1_b, b2_b});
    end
    rst = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if ({en_a, v_a, busy_a, done_a, en_b, v_b, busy_b, done_b} !== '0) begin
      miscompares++;
      $display("FAIL reset_release: got %b want 0", {en_a, v_a, busy_a, done_a, en_b, v_b, busy_b, done_b});
    end
  endtask

  task automatic test_basic();
    mem1[12'h010] = 64'h0807060504030201;
    mem2[12'h810] = 64'h1817161514131211;
    run(1'b0, 12'h010, 12'h810, 1, 100, 0, 0);
    vectors++;
    if (stream_diff() !== 0) begin miscompares++; $display("FAIL basic_stream: %0d diffs want 0", stream_diff()); end
    vectors++;
    if (got1.size() != 8 || got1[0] !== 8'h01 || got1[7] !== 8'h08 || got2[0] !== 8'h11 || got2[7] !== 8'h18) begin
      miscompares++;
      $display("FAIL basic_bytes: size %0d first %h/%h want 8 bytes 01..08 / 11..18", got1.size(), got1[0], got2[0]);
    end
    vectors++;
    if (first_valid !== 3) begin miscompares++; $display("FAIL basic_latency: first valid T0+%0d want T0+3", first_valid); end
    vectors++;
    if (last_err !== 0) begin miscompares++; $display("FAIL basic_last: %0d bad cycles want 0", last_err); end
    vectors++;
    if (done_cyc !== 1 || done_busy_err !== 0) begin
      miscompares++;
      $display("FAIL basic_done: delay %0d busy_err %0d want 1/0", done_cyc, done_busy_err);
    end
    vectors++;
    if (n_en !== 1 || timeout !== 0) begin miscompares++; $display("FAIL basic_en: en %0d timeout %0d want 1/0", n_en, timeout); end
  endtask

  task automatic test_full_rate();
    run(1'b0, 12'h010, 12'h810, 3, 100, 0, 0);
    vectors++;
    if (stream_diff() !== 0) begin miscompares++; $display("FAIL full_stream: %0d diffs want 0", stream_diff()); end
    vectors++;
    if (n_valid !== 24 || bubbles !== 0) begin
      miscompares++;
      $display("FAIL full_rate: valid %0d bubbles %0d want 24/0", n_valid, bubbles);
    end
    vectors++;
    if (n_en !== 3 || addr_diff() !== 0) begin
      miscompares++;
      $display("FAIL full_addr: en %0d addr diffs %0d want 3/0", n_en, addr_diff());
    end
  endtask

  task automatic test_backpressure();
    run(1'b0, AW'($urandom_range(4095)), AW'($urandom_range(4095)), 4, 30, 0, 0);
    vectors++;
    if (stream_diff() !== 0 || got1.size() != 32) begin
      miscompares++;
      $display("FAIL bp_stream: %0d diffs %0d bytes want 0/32", stream_diff(), got1.size());
    end
    vectors++;
    if (stab_err !== 0) begin miscompares++; $display("FAIL bp_stable: %0d unstable stalls want 0", stab_err); end
    vectors++;
    if (outst_err !== 0) begin miscompares++; $display("FAIL bp_outstanding: %0d overruns want 0", outst_err); end
    vectors++;
    if (last_err !== 0 || timeout !== 0) begin
      miscompares++;
      $display("FAIL bp_last: last_err %0d timeout %0d want 0/0", last_err, timeout);
    end
  endtask

  task automatic test_empty();
    run(1'b0, AW'($urandom_range(4095)), AW'($urandom_range(4095)), 0, 100, 0, 0);
    vectors++;
    if (done_cyc !== 1) begin miscompares++; $display("FAIL empty_done: done at T0+%0d want T0+1", done_cyc); end
    vectors++;
    if (n_en !== 0 || n_hs !== 0) begin miscompares++; $display("FAIL empty_en: en %0d bytes %0d want 0/0", n_en, n_hs); end
  endtask

  task automatic test_wrap();
    run(1'b0, 12'hFFF, AW'($urandom_range(4095)), 2, 100, 0, 0);
    vectors++;
    if (ga1.size() != 2 || ga1[0] !== 12'hFFF || ga1[1] !== 12'h000) begin
      miscompares++;
      $display("FAIL wrap_addr: %0d reads first %h second %h want FFF then 000", ga1.size(), ga1[0], ga1[1]);
    end
    vectors++;
    if (stream_diff() !== 0 || addr_diff() !== 0) begin
      miscompares++;
      $display("FAIL wrap_stream: %0d byte diffs %0d addr diffs want 0/0", stream_diff(), addr_diff());
    end
  endtask

  task automatic test_mid_start();
    int extra;
    run(1'b0, AW'($urandom_range(4095)), AW'($urandom_range(4095)), 2, 100, 6, 0);
    vectors++;
    if (n_hs !== 16 || stream_diff() !== 0) begin
      miscompares++;
      $display("FAIL mid_start_count: %0d bytes %0d diffs want 16/0", n_hs, stream_diff());
    end
    extra = 0;
    repeat (10) begin
      @(negedge clk);
      if (en_a || v_a || busy_a) extra++;
    end
    vectors++;
    if (extra !== 0) begin miscompares++; $display("FAIL mid_start_idle: %0d active cycles want 0", extra); end
  endtask

  task automatic test_reset_mid();
    int stale;
    run(1'b0, AW'($urandom_range(4095)), AW'($urandom_range(4095)), 2, 100, 0, 5);
    rst = 1'b0;
    #1;
    vectors++;
    if ({en_a, v_a, l_a, busy_a, done_a, a1_a, a2_a, b1_a, b2_a} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_outputs: got %h want 0", {en_a, v_a, l_a, busy_a, done_a, a1_a, a2_a, b1_a, b2_a});
    end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    stale = 0;
    repeat (4) begin
      @(negedge clk);
      if (en_a || v_a || busy_a || done_a) stale++;
    end
    vectors++;
    if (stale !== 0) begin miscompares++; $display("FAIL reset_mid_stale: %0d active cycles want 0", stale); end
    run(1'b0, AW'($urandom_range(4095)), AW'($urandom_range(4095)), 2, 60, 0, 0);
    vectors++;
    if (stream_diff() !== 0 || n_hs !== 16 || timeout !== 0) begin
      miscompares++;
      $display("FAIL reset_mid_restart: %0d diffs %0d bytes timeout %0d want 0/16/0", stream_diff(), n_hs, timeout);
    end
  endtask

  task automatic test_rd_lat2();
    run(1'b1, 12'h010, 12'h810, 3, 100, 0, 0);
    vectors++;
    if (first_valid !== 4) begin miscompares++; $display("FAIL lat2_latency: first valid T0+%0d want T0+4", first_valid); end
    vectors++;
    if (n_valid !== 24 || bubbles !== 0) begin
      miscompares++;
      $display("FAIL lat2_rate: valid %0d bubbles %0d want 24/0", n_valid, bubbles);
    end
    vectors++;
    if (stream_diff() !== 0 || addr_diff() !== 0) begin
      miscompares++;
      $display("FAIL lat2_stream: %0d byte diffs %0d addr diffs want 0/0", stream_diff(), addr_diff());
    end
  endtask

  task automatic test_random();
    int cnt, duty;
    logic s;
    for (int it = 0; it < 8; it++) begin
      s    = 1'($urandom_range(1));
      cnt  = $urandom_range(6, 1);
      duty = $urandom_range(100, 20);
      run(s, AW'($urandom_range(4095)), AW'($urandom_range(4095)), cnt, duty, 0, 0);
      vectors++;
      if (stream_diff() !== 0 || addr_diff() !== 0) begin
        miscompares++;
        $display("FAIL random_stream[%0d]: lat%0d cnt %0d %0d byte diffs %0d addr diffs want 0/0",
                 it, s + 1, cnt, stream_diff(), addr_diff());
      end
      vectors++;
      if (stab_err !== 0 || outst_err !== 0 || last_err !== 0 || done_cyc !== 1 || timeout !== 0) begin
        miscompares++;
        $display("FAIL random_proto[%0d]: stab %0d outst %0d last %0d done %0d timeout %0d want 0/0/0/1/0",
                 it, stab_err, outst_err, last_err, done_cyc, timeout);
      end
    end
  endtask

  initial begin
    rst = 1'b0; start_a = 1'b0; start_b = 1'b0; ready = 1'b0; sel = 1'b0;
    base_1 = '0; base_2 = '0; wcnt = '0;
    for (int i = 0; i < 4096; i++) begin
      mem1[i] = {$urandom, $urandom};
      mem2[i] = {$urandom, $urandom};
    end
    test_reset();
    test_basic();
    test_full_rate();
    test_backpressure();
    test_empty();
    test_wrap();
    test_mid_start();
    test_reset_mid();
    test_rd_lat2();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
